// File: rtl/fetch_unit_if.sv
// IF/ID handshake between the fetch stage (master) and decode (slave).
interface fetch_unit_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  modport master (
    output out_valid,
    output out_instruction,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction_memory combinationally and
// presents each fetched instruction with its PC to decode through a valid/ready IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_pc,
  input  logic [31:0]        imem_instruction,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  fetch_unit_if.master       out_if,
  output logic               halted,
  output logic               fetch_error,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] MemEnd = 32'(MEM_BYTES);
  localparam logic [31:0] LastPc = 32'(MEM_BYTES - 4);
  localparam logic [31:0] Step   = 32'(PC_STEP);

  typedef enum logic [1:0] {StRun, StHalt, StError} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] count_q, count_d;

  logic redirect_act;
  logic load_act;

  // Redirects are dropped once in ERROR; only reset leaves that state.
  assign redirect_act = redirect_valid && (state_q != StError);
  assign load_act     = !redirect_act && (state_q == StRun) && (pc_q <= LastPc) &&
                        (!valid_q || out_if.out_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    count_d = count_q;

    if (redirect_act) begin
      valid_d = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        state_d = StError;
      end else if (redirect_target >= MemEnd) begin
        pc_d    = redirect_target;
        state_d = StHalt;
      end else begin
        pc_d    = redirect_target;
        state_d = StRun;
      end
    end else if (load_act) begin
      valid_d = 1'b1;
      instr_d = imem_instruction;
      opc_d   = pc_q;
      pc_d    = pc_q + Step;
      count_d = count_q + 32'd1;
    end else begin
      if (out_if.out_ready) begin
        valid_d = 1'b0;
      end
      if ((state_q == StRun) && (pc_q > LastPc)) begin
        state_d = StHalt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      opc_q   <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      count_q <= count_d;
    end
  end

  // Hold the memory address at the reset PC for the whole reset window, not just after the first edge.
  assign imem_pc                = reset ? RESET_PC : pc_q;
  assign out_if.out_valid       = valid_q;
  assign out_if.out_instruction = instr_q;
  assign out_if.out_pc          = opc_q;
  assign halted                 = (state_q == StHalt);
  assign fetch_error            = (state_q == StError);
  assign fetch_count            = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural instruction_memory and a
// scoreboard of expected (pc, instruction) pairs popped on each IF/ID handshake.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
  logic        fetch_error;
  logic [31:0] fetch_count;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'd0),
    .MEM_BYTES (32),
    .PC_STEP   (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_if           (bus),
    .halted           (halted),
    .fetch_error      (fetch_error),
    .fetch_count      (fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'd0:   rom = 32'h00940300;
      32'd4:   rom = 32'h41390301;
      32'd8:   rom = 32'h035A0205;
      32'd12:  rom = 32'h017B4E04;
      32'd16:  rom = 32'h019C1E08;
      32'd20:  rom = 32'h22AA5507;
      32'd24:  rom = 32'h13579BDF;
      32'd28:  rom = 32'h00F76803;
      default: rom = 32'h00000000;
    endcase
  endfunction

  assign imem_instruction = rom(imem_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb_entry_t e;
    e.pc    = pc;
    e.instr = rom(pc);
    sb.push_back(e);
  endtask

  task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] p = lo; p <= hi; p += 32'd4) push(p);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  always @(negedge clk) begin
    sb_entry_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", bus.out_pc, e.pc);
        check("sb_instr", bus.out_instruction, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    bus.out_ready   = 1'b1;

    // Reset state, then free-running fetch to the end of memory.
    step();
    step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_imem_pc", imem_pc, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(fetch_error), 32'd0);
    push_range(32'd0, 32'd28);
    reset = 1'b0;
    step();
    check("t1_first_valid", 32'(bus.out_valid), 32'd1);
    check("t1_first_pc", bus.out_pc, 32'd0);
    check("t1_first_instr", bus.out_instruction, 32'h00940300);
    wait_halt();
    check("t1_count", fetch_count, 32'd8);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure holds the IF/ID entry and the PC.
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("t2_load_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_pc", bus.out_pc, 32'd0);
      check("t2_hold_instr", bus.out_instruction, 32'h00940300);
      check("t2_hold_imem_pc", imem_pc, 32'd4);
    end
    push(32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t2_resume_pc", bus.out_pc, 32'd4);
    check("t2_resume_instr", bus.out_instruction, 32'h41390301);

    // Redirect while stalled flushes the held entry.
    redirect_valid  = 1'b1;
    redirect_target = 32'd16;
    step();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(bus.out_valid), 32'd0);
    check("t3_imem_pc", imem_pc, 32'd16);
    step();
    check("t3_target_valid", 32'(bus.out_valid), 32'd1);
    check("t3_target_pc", bus.out_pc, 32'd16);
    check("t3_target_instr", bus.out_instruction, 32'h019C1E08);
    push_range(32'd16, 32'd28);
    bus.out_ready = 1'b1;
    wait_halt();
    check("t3_count", fetch_count, 32'd6);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect out of HALT resumes fetching.
    push_range(32'd8, 32'd28);
    redirect_valid  = 1'b1;
    redirect_target = 32'd8;
    step();
    redirect_valid = 1'b0;
    check("t4_unhalt", 32'(halted), 32'd0);
    check("t4_imem_pc", imem_pc, 32'd8);
    wait_halt();
    check("t4_count", fetch_count, 32'd12);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Misaligned redirect: sticky error, further redirects ignored.
    bus.out_ready   = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'd0;
    step();
    redirect_valid = 1'b0;
    step();
    check("t5_pre_valid", 32'(bus.out_valid), 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'd6;
    step();
    redirect_valid = 1'b0;
    check("t5_error", 32'(fetch_error), 32'd1);
    check("t5_not_halted", 32'(halted), 32'd0);
    check("t5_flushed", 32'(bus.out_valid), 32'd0);
    check("t5_pc_kept", imem_pc, 32'd4);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("t5_no_load", 32'(bus.out_valid), 32'd0);
    check("t5_count", fetch_count, 32'd13);
    redirect_valid  = 1'b1;
    redirect_target = 32'd0;
    step();
    redirect_valid = 1'b0;
    check("t5_ignored_pc", imem_pc, 32'd4);
    check("t5_still_error", 32'(fetch_error), 32'd1);
    step();
    check("t5_still_idle", 32'(bus.out_valid), 32'd0);
    reset = 1'b1;
    step();
    check("t5_rst_error", 32'(fetch_error), 32'd0);
    check("t5_rst_imem_pc", imem_pc, 32'd0);

    // Reset mid-stream discards IF/ID contents and a pending redirect.
    step();
    reset = 1'b0;
    push(32'd0);
    step();
    step();
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    check("t6_pre_pc", bus.out_pc, 32'd4);
    reset           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'd16;
    step();
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_count", fetch_count, 32'd0);
    check("t6_rst_imem_pc", imem_pc, 32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    push(32'd0);
    step();
    check("t6_post_pc", bus.out_pc, 32'd0);
    check("t6_post_count", fetch_count, 32'd1);
    step();
    bus.out_ready = 1'b0;
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
